// File: rtl/cclimb_rom_loader.sv
// ROM download sequencer: forwards ioctl bytes to the core loader, holds the core in reset
// around downloads, and flags wrong-length images. Optional checksum: CCLIMB_ROM_CHECKSUM_EN.
module cclimb_rom_loader #(
    parameter logic [16:0] EXPECT_SIZE = 17'h0B000,
    parameter logic [15:0] GFX_BASE    = 16'h6000,
    parameter logic [15:0] PROM_BASE   = 16'hA000,
    parameter int          HOLD_CYCLES = 64,
    parameter logic [7:0]  EXPECT_SUM  = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  dn_region,
    output logic        core_reset,
    output logic        dl_busy,
    output logic        size_err,
    output logic        cksum_ok
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [24:0]   SIZE_LIMIT = {8'd0, EXPECT_SIZE};

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_cnt;
    logic [16:0]     byte_cnt;
    logic [16:0]     byte_cnt_next;
    logic            in_load;
    logic            in_range;
    logic            wr_ok;
    logic            wr_bad;
    logic            load_entry;
    logic            hold_entry;
    logic            load_exit;
    logic [1:0]      region_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (ioctl_download)
                    state_d = ST_LOAD;
                else if (hold_cnt == HOLD_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ioctl_download)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download)
                    state_d = ST_HOLD;
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        core_reset    = 1'b1;
        dl_busy       = 1'b0;
        in_load       = (state_q == ST_LOAD);
        in_range      = (ioctl_addr < SIZE_LIMIT);
        wr_ok         = 1'b0;
        wr_bad        = 1'b0;
        load_entry    = (state_d == ST_LOAD) && !in_load;
        hold_entry    = (state_d == ST_HOLD) && (state_q != ST_HOLD);
        load_exit     = in_load && !ioctl_download;
        byte_cnt_next = byte_cnt;
        region_d      = 2'd0;
        if (state_q == ST_RUN)
            core_reset = 1'b0;
        if (in_load)
            dl_busy = 1'b1;
        if (in_load && ioctl_wr) begin
            wr_ok  = in_range;
            wr_bad = !in_range;
        end
        if (wr_ok)
            byte_cnt_next = byte_cnt + 17'd1;
        if (ioctl_addr[15:0] >= PROM_BASE)
            region_d = 2'd2;
        else if (ioctl_addr[15:0] >= GFX_BASE)
            region_d = 2'd1;
    end

    // The byte accepted on the download-falling cycle is already folded into byte_cnt_next.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            hold_cnt  <= '0;
            dn_wr     <= 1'b0;
            dn_addr   <= 16'd0;
            dn_data   <= 8'd0;
            dn_region <= 2'd0;
            byte_cnt  <= 17'd0;
            size_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hold_entry)
                hold_cnt <= '0;
            else if (state_q == ST_HOLD)
                hold_cnt <= hold_cnt + 1'b1;
            dn_wr <= wr_ok;
            if (wr_ok) begin
                dn_addr   <= ioctl_addr[15:0];
                dn_data   <= ioctl_dout;
                dn_region <= region_d;
            end
            if (load_entry)
                byte_cnt <= 17'd0;
            else
                byte_cnt <= byte_cnt_next;
            if (load_entry)
                size_err <= 1'b0;
            else if (wr_bad || (load_exit && (byte_cnt_next != EXPECT_SIZE)))
                size_err <= 1'b1;
        end
    end

`ifdef CCLIMB_ROM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_next;
    logic       cksum_q;

    always_comb begin
        sum_next = sum_q;
        if (wr_ok)
            sum_next = sum_q + ioctl_dout;
    end

    // Verdict is latched only when a download ends, so it stays valid while the core runs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q   <= 8'd0;
            cksum_q <= 1'b1;
        end else begin
            if (load_entry)
                sum_q <= 8'd0;
            else
                sum_q <= sum_next;
            if (load_exit)
                cksum_q <= (sum_next == EXPECT_SUM);
        end
    end

    assign cksum_ok = cksum_q;
`else
    assign cksum_ok = 1'b1;
`endif

endmodule
